// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream checker and generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2,
    DONE  = 2'd3
  } fib_state_e;

  localparam int          FIB_WIDTH         = 32;
  localparam logic [31:0] FIB47             = 32'd2971215073;
  localparam int          FIB_TERM_LIMIT_32 = 48;

endpackage : fib_pkg

// File: rtl/fib_term_gen.sv
// Term sequencer: holds the current (e0) and following (e1) Fibonacci terms
// plus flags saying whether each still fits in WIDTH bits.
module fib_term_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic             resync_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] e0_o,
  output logic             e0_ok_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic             e0_ok_q, e0_ok_d;
  logic             e1_ok_q, e1_ok_d;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, e0_q} + {1'b0, e1_q};

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    e0_ok_d = e0_ok_q;
    e1_ok_d = e1_ok_q;
    if (restart_i) begin
      e0_d    = '0;
      e1_d    = ONE;
      e0_ok_d = 1'b1;
      e1_ok_d = 1'b1;
    end else if (resync_i) begin
      // A received 0 stands in for term 0, so term 1 is expected next.
      e0_d    = ONE;
      e1_d    = ONE;
      e0_ok_d = 1'b1;
      e1_ok_d = 1'b1;
    end else if (advance_i) begin
      e0_d    = e1_q;
      e1_d    = sum[WIDTH-1:0];
      e0_ok_d = e1_ok_q;
      e1_ok_d = e1_ok_q & ~sum[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= ONE;
      e0_ok_q <= 1'b1;
      e1_ok_q <= 1'b1;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      e0_ok_q <= e0_ok_d;
      e1_ok_q <= e1_ok_d;
    end
  end

  assign e0_o    = e0_q;
  assign e0_ok_o = e0_ok_q;

endmodule : fib_term_gen

// File: rtl/fib_stream_checker.sv
// Checks a valid/data stream against 0,1,1,2,3,5,... and reports lock, errors and overflow.
// Optional macro FIB_CHK_RESYNC_EN: a received 0 after a mismatch restarts tracking.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] term_cnt,
  output logic [WIDTH-1:0] exp_data,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fib_state_e       state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic             ovf_q, ovf_d;

  logic             advance;
  logic             resync;
  logic [WIDTH-1:0] e0;
  logic             e0_ok;
  logic             match;

  fib_term_gen #(
    .WIDTH (WIDTH)
  ) u_term_gen (
    .clk       (clk),
    .rst_n     (rst),
    .restart_i (clr),
    .resync_i  (resync),
    .advance_i (advance),
    .e0_o      (e0),
    .e0_ok_o   (e0_ok)
  );

  assign match = (in_data == e0);

  always_comb begin
    state_d     = state_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    term_cnt_d  = term_cnt_q;
    ovf_d       = ovf_q;
    advance     = 1'b0;
    resync      = 1'b0;
    if (clr) begin
      state_d    = IDLE;
      err_cnt_d  = '0;
      term_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (in_valid && (state_q != DONE)) begin
      if (!e0_ok) begin
        // Expected term no longer fits: stop checking without counting it.
        state_d = DONE;
        ovf_d   = 1'b1;
      end else begin
        advance    = 1'b1;
        term_cnt_d = (term_cnt_q == CNT_MAX) ? term_cnt_q : term_cnt_q + CNT_ONE;
        if (!match) begin
          err_pulse_d = 1'b1;
          err_cnt_d   = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;
        end
        case (state_q)
          IDLE, TRACK: state_d = match ? TRACK : ERROR;
          default:     state_d = state_q;
        endcase
`ifdef FIB_CHK_RESYNC_EN
        if (!match && (in_data == '0) && ((state_q == TRACK) || (state_q == ERROR))) begin
          advance    = 1'b0;
          resync     = 1'b1;
          state_d    = TRACK;
          term_cnt_d = CNT_ONE;
        end
`endif
      end
    end
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      term_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      term_cnt_q  <= term_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign term_cnt  = term_cnt_q;
  assign exp_data  = e0;
  assign ovf       = ovf_q;

endmodule : fib_stream_checker
